// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if
//   Bundles the operation-side and result-side handshakes of the ALU
//   execution unit.
//   master : the environment (operand fetch upstream, writeback downstream)
//   slave  : the execution unit itself
//   Operation side : in_valid, in_ready, ALUControl, srca, srcb
//   Result side    : out_valid, out_ready, out_result, out_zero, out_ovf,
//                    out_illegal
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_ovf;
  logic             out_illegal;

  modport master (
    output in_valid, ALUControl, srca, srcb, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_ovf, out_illegal
  );

  modport slave (
    input  in_valid, ALUControl, srca, srcb, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_ovf, out_illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Executes one ALUControl operation per accepted input and buffers the
//   result in a two-entry output stage (main + skid), so writeback may stall
//   without losing operations. in_ready depends only on the buffer state.
// Ports
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : alu_exec_unit_if.slave (operation in, result out handshakes)
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  alu_exec_unit_if.slave bus
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic             illegal;
  } entry_t;

  // State encodes how many entries are held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t new_entry;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             in_ready_int;
  logic             out_valid_int;
  logic             accept;
  logic             pop;

  // Combinational execute on the incoming operands.
  always_comb begin
    sum       = bus.srca + bus.srcb;
    diff      = bus.srca - bus.srcb;
    new_entry = '0;
    case (bus.ALUControl)
      3'b000: begin
        new_entry.result = sum;
        new_entry.ovf    = (bus.srca[WIDTH-1] == bus.srcb[WIDTH-1]) &&
                           (sum[WIDTH-1] != bus.srca[WIDTH-1]);
      end
      3'b001: begin
        new_entry.result = diff;
        new_entry.ovf    = (bus.srca[WIDTH-1] != bus.srcb[WIDTH-1]) &&
                           (diff[WIDTH-1] != bus.srca[WIDTH-1]);
      end
      3'b010: new_entry.result = bus.srca & bus.srcb;
      3'b011: new_entry.result = bus.srca | bus.srcb;
      3'b101: new_entry.result = {{(WIDTH-1){1'b0}},
                                  ($signed(bus.srca) < $signed(bus.srcb))};
      // Undefined codes, including X/Z in simulation, land here.
      default: new_entry.illegal = 1'b1;
    endcase
    new_entry.zero = (new_entry.result == '0);
  end

  assign in_ready_int  = (state_q != FULL);
  assign out_valid_int = (state_q != EMPTY);
  assign accept        = bus.in_valid && in_ready_int;
  assign pop           = out_valid_int && bus.out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state and buffer update
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          main_d  = new_entry;
        end
      end
      ONE: begin
        if (accept && pop) begin
          main_d = new_entry;
        end else if (accept) begin
          state_d = FULL;
          skid_d  = new_entry;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Outputs: always present the main entry; it keeps its value when EMPTY.
  always_comb begin
    bus.in_ready    = in_ready_int;
    bus.out_valid   = out_valid_int;
    bus.out_result  = main_q.result;
    bus.out_zero    = main_q.zero;
    bus.out_ovf     = main_q.ovf;
    bus.out_illegal = main_q.illegal;
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  localparam int WIDTH = 32;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  alu_exec_unit_if #(.WIDTH(WIDTH)) bus ();

  alu_exec_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one operation for one cycle; returns at the negedge after the
  // accepting edge with in_valid dropped.
  task automatic apply_op(input logic [2:0] code, input logic [31:0] a,
                          input logic [31:0] b);
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.ALUControl = code;
    bus.srca       = a;
    bus.srcb       = b;
    @(negedge clk);
    bus.in_valid   = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.ALUControl = 3'b000;
    bus.srca = '0;
    bus.srcb = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_hs: out_valid=%b in_ready=%b, required 0/1", bus.out_valid, bus.in_ready);
    end
    vectors++;
    if (bus.out_result !== 32'h0 || bus.out_zero !== 1'b0 || bus.out_ovf !== 1'b0 || bus.out_illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_data: result=%h z=%b o=%b i=%b, required 0/0/0/0",
               bus.out_result, bus.out_zero, bus.out_ovf, bus.out_illegal);
    end
  endtask

  task automatic test_add;
    apply_op(3'b000, 32'd7, 32'd5);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd12 || bus.out_zero !== 1'b0 ||
        bus.out_ovf !== 1'b0 || bus.out_illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL add_7_5: v=%b result=%h z=%b o=%b i=%b, required 1/0000000c/0/0/0",
               bus.out_valid, bus.out_result, bus.out_zero, bus.out_ovf, bus.out_illegal);
    end
    apply_op(3'b000, 32'h7FFFFFFF, 32'h1);
    vectors++;
    if (bus.out_result !== 32'h80000000 || bus.out_ovf !== 1'b1 || bus.out_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL add_ovf: result=%h o=%b z=%b, required 80000000/1/0",
               bus.out_result, bus.out_ovf, bus.out_zero);
    end
  endtask

  task automatic test_sub;
    apply_op(3'b001, 32'h1234, 32'h1234);
    vectors++;
    if (bus.out_result !== 32'h0 || bus.out_zero !== 1'b1 || bus.out_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL sub_zero: result=%h z=%b o=%b, required 00000000/1/0",
               bus.out_result, bus.out_zero, bus.out_ovf);
    end
    apply_op(3'b001, 32'h80000000, 32'h1);
    vectors++;
    if (bus.out_result !== 32'h7FFFFFFF || bus.out_ovf !== 1'b1 || bus.out_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL sub_ovf: result=%h o=%b z=%b, required 7fffffff/1/0",
               bus.out_result, bus.out_ovf, bus.out_zero);
    end
  endtask

  task automatic test_slt_illegal;
    apply_op(3'b101, 32'hFFFFFFFF, 32'h1);
    vectors++;
    if (bus.out_result !== 32'h1 || bus.out_zero !== 1'b0 || bus.out_illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL slt_neg_lt_pos: result=%h z=%b i=%b, required 00000001/0/0",
               bus.out_result, bus.out_zero, bus.out_illegal);
    end
    apply_op(3'b101, 32'h1, 32'hFFFFFFFF);
    vectors++;
    if (bus.out_result !== 32'h0 || bus.out_zero !== 1'b1) begin
      miscompares++;
      $display("FAIL slt_pos_lt_neg: result=%h z=%b, required 00000000/1",
               bus.out_result, bus.out_zero);
    end
    apply_op(3'b110, 32'h5, 32'h3);
    vectors++;
    if (bus.out_result !== 32'h0 || bus.out_illegal !== 1'b1 || bus.out_zero !== 1'b1 || bus.out_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_110: result=%h i=%b z=%b o=%b, required 00000000/1/1/0",
               bus.out_result, bus.out_illegal, bus.out_zero, bus.out_ovf);
    end
    apply_op(3'b100, 32'h7FFFFFFF, 32'h7FFFFFFF);
    vectors++;
    if (bus.out_result !== 32'h0 || bus.out_illegal !== 1'b1 || bus.out_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_100: result=%h i=%b o=%b, required 00000000/1/0",
               bus.out_result, bus.out_illegal, bus.out_ovf);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.ALUControl = 3'b000; bus.srca = 32'h1; bus.srcb = 32'h1;
    @(negedge clk);  // op1 accepted -> ONE
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_result !== 32'h2) begin
      miscompares++;
      $display("FAIL b2b_one: in_ready=%b v=%b result=%h, required 1/1/00000002",
               bus.in_ready, bus.out_valid, bus.out_result);
    end
    bus.ALUControl = 3'b011; bus.srca = 32'hF0; bus.srcb = 32'h0F;
    @(negedge clk);  // op2 accepted -> FULL
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.out_result !== 32'h2) begin
      miscompares++;
      $display("FAIL b2b_full: in_ready=%b result=%h, required 0/00000002",
               bus.in_ready, bus.out_result);
    end
    bus.ALUControl = 3'b010; bus.srca = 32'hFF; bus.srcb = 32'h0F;
    @(negedge clk);  // op3 held off
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_result !== 32'h2) begin
      miscompares++;
      $display("FAIL b2b_stall: in_ready=%b v=%b result=%h, required 0/1/00000002",
               bus.in_ready, bus.out_valid, bus.out_result);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);  // pop op1, skid moves to main
    vectors++;
    if (bus.out_result !== 32'hFF || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second: result=%h in_ready=%b v=%b, required 000000ff/1/1",
               bus.out_result, bus.in_ready, bus.out_valid);
    end
    @(negedge clk);  // accept op3 and pop op2 in ONE
    vectors++;
    if (bus.out_result !== 32'h0F || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_third: result=%h in_ready=%b v=%b, required 0000000f/1/1",
               bus.out_result, bus.in_ready, bus.out_valid);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);  // pop op3 -> EMPTY, data retained
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_result !== 32'h0F) begin
      miscompares++;
      $display("FAIL b2b_drain: v=%b result=%h, required 0/0000000f",
               bus.out_valid, bus.out_result);
    end
  endtask

  task automatic test_reset_full;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.ALUControl = 3'b000; bus.srca = 32'h50; bus.srcb = 32'h5;
    @(negedge clk);
    bus.srca = 32'h60; bus.srcb = 32'h6;
    @(negedge clk);
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.out_result !== 32'h55) begin
      miscompares++;
      $display("FAIL rst_full_pre: in_ready=%b result=%h, required 0/00000055",
               bus.in_ready, bus.out_result);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_result !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_full_post: v=%b in_ready=%b result=%h, required 0/1/00000000",
               bus.out_valid, bus.in_ready, bus.out_result);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_no_emit[%0d]: v=%b result=%h, required v=0", i, bus.out_valid, bus.out_result);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_add();
    test_sub();
    test_slt_illegal();
    test_back_to_back();
    test_reset_full();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
